// File: rtl/line_memory.sv
// line_memory: multi-cycle, word-addressed main memory that serves whole cache
// lines to the L1 controller. One request is outstanding at a time. The request
// port is valid/ready, and completion is signalled by a one-cycle resp_valid pulse.
// Optional build macro LINE_MEMORY_ADDR_CHECK_EN flags addresses that have
// bits set above ADDR_W on resp_err. It also prints a warning when such a
// request is accepted. The access itself still uses the aliased address.
module line_memory #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 12,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [31:0]                  req_addr,
    input  logic [DATA_W*LINE_WORDS-1:0] req_wdata,
    output logic                         resp_valid,
    output logic [DATA_W*LINE_WORDS-1:0] resp_rdata,
    output logic                         resp_err
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int LINE_W = DATA_W * LINE_WORDS;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  mem [0:(2**IDX_W)-1];

    // The commit/sample cycle: last BUSY cycle before the response.
    logic last_busy;
    assign last_busy = (state == BUSY) && (count == '0);

    // Offset bits and bits above ADDR_W never select storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W], req_addr[OFF_W-1:0]};

    // Request FSM: accept, count down the latency, then pulse the response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        idx_q     <= req_addr[ADDR_W-1:OFF_W];
                        wdata_q   <= req_wdata;
                        count     <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        // Writes leave resp_rdata holding the last read line.
                        if (!we_q) resp_rdata <= mem[idx_q];
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Array write port. A reset aborts BUSY, so an aborted write never commits.
    always_ff @(posedge clock) begin
        if (last_busy && we_q) mem[idx_q] <= wdata_q;
    end

`ifdef LINE_MEMORY_ADDR_CHECK_EN
    logic err_q;

    // Range check: latch at accept, present only during the response cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q    <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                err_q <= |req_addr[31:ADDR_W];
                if (|req_addr[31:ADDR_W])
                    $display("line_memory: warning: address %h beyond %0d-bit range at time %0t",
                             req_addr, ADDR_W, $time);
            end
            resp_err <= last_busy ? err_q : 1'b0;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory (LATENCY=4, LINE_WORDS=4, ADDR_W=12).
// Accepted requests push their expected response to a scoreboard queue.
// A negedge monitor pops and compares each entry when resp_valid is seen.
module tb_line_memory;

    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int LW  = 4;
    localparam int LAT = 4;
    localparam int LB  = DW * LW;
`ifdef LINE_MEMORY_ADDR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef logic [LB-1:0] line_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        line_t       data;
        logic        err;
        int          acc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        line_t       data;   // write data, or expected read data
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    line_t       req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    line_t       resp_rdata;
    logic        resp_err;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_acc = 0;
    line_t last_rd = '0;

    always #5 clock = ~clock;

    line_memory #(.DATA_W(DW), .ADDR_W(AW), .LINE_WORDS(LW), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic line_t mk(input logic [31:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic exp_err(input logic [31:0] a);
        return (a[31:AW] != '0) && ERR_EN;
    endfunction

    // Response monitor / scoreboard consumer.
    always @(negedge clock) begin
        exp_t e;
        if (reset && resp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=1 required=0");
            end else begin
                e = sbq.pop_front();
                chk("resp_latency", line_t'(cyc - e.acc), line_t'(LAT));
                chk("resp_err", line_t'(resp_err), line_t'(e.err));
                if (e.we) begin
                    chk("rdata_hold_on_write", resp_rdata, last_rd);
                end else begin
                    chk("read_data", resp_rdata, e.data);
                    last_rd = e.data;
                end
            end
        end else if (reset) begin
            chk("resp_err_idle", line_t'(resp_err), '0);
        end
    end

    // Called at a negedge: present a request, hold until accepted, push expectation.
    task automatic issue(input logic we, input logic [31:0] addr, input line_t data,
                         output int waits);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        waits     = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clock);
            waits++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else begin
            sbq.push_back('{we, addr, data, exp_err(addr), cyc + 1});
            last_acc = cyc + 1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        req_valid = 1'b0;
        while ((sbq.size() != 0 || !req_ready) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[$];
        int   w;
        int   a1;

        vecs.push_back('{1'b1, 32'h010, mk(32'h11, 32'h22, 32'h33, 32'h44)});
        vecs.push_back('{1'b0, 32'h013, mk(32'h11, 32'h22, 32'h33, 32'h44)});
        vecs.push_back('{1'b1, 32'h000, mk(100, 101, 102, 103)});
        vecs.push_back('{1'b1, 32'h004, mk(200, 201, 202, 203)});
        vecs.push_back('{1'b1, 32'h020, mk(1, 2, 3, 4)});
        vecs.push_back('{1'b1, 32'h030, '0});
        vecs.push_back('{1'b1, 32'h010, mk(32'hA, 32'hB, 32'hC, 32'hD)});
        vecs.push_back('{1'b0, 32'h1010, mk(32'hA, 32'hB, 32'hC, 32'hD)});
        vecs.push_back('{1'b1, 32'hFFC, mk(7, 77, 777, 7777)});
        vecs.push_back('{1'b0, 32'h3FFE, mk(7, 77, 777, 7777)});
        vecs.push_back('{1'b0, 32'h002, mk(100, 101, 102, 103)});
        vecs.push_back('{1'b0, 32'h010, mk(32'hA, 32'hB, 32'hC, 32'hD)});

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_ready", line_t'(req_ready), line_t'(1));
        chk("reset_resp_valid", line_t'(resp_valid), '0);
        chk("reset_rdata", resp_rdata, '0);
        chk("reset_err", line_t'(resp_err), '0);
        reset = 1'b1;
        @(negedge clock);

        // Table-driven isolated accesses
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].data, w);
            wait_idle();
        end

        // Back-to-back reads with req_valid held high
        issue(1'b0, 32'h000, mk(100, 101, 102, 103), w);
        a1 = last_acc;
        issue(1'b0, 32'h004, mk(200, 201, 202, 203), w);
        chk("b2b_ready_low_cycles", line_t'(w), line_t'(LAT + 1));
        chk("b2b_accept_spacing", line_t'(last_acc - a1), line_t'(LAT + 2));
        wait_idle();

        // Write offered while busy must be ignored
        issue(1'b0, 32'h020, mk(1, 2, 3, 4), w);
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h020;
        req_wdata = mk(9, 9, 9, 9);
        chk("busy_ready_low", line_t'(req_ready), '0);
        @(negedge clock);
        wait_idle();
        issue(1'b0, 32'h020, mk(1, 2, 3, 4), w);
        wait_idle();

        // Reset during BUSY aborts a pending write
        issue(1'b1, 32'h030, mk(5, 6, 7, 8), w);
        req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("abort_ready", line_t'(req_ready), line_t'(1));
        chk("abort_resp_valid", line_t'(resp_valid), '0);
        chk("abort_rdata", resp_rdata, '0);
        sbq.delete();
        last_rd = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        issue(1'b0, 32'h030, '0, w);
        wait_idle();

        // Read immediately following a write to the same line
        issue(1'b1, 32'h040, mk(32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D), w);
        a1 = last_acc;
        issue(1'b0, 32'h040, mk(32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D), w);
        chk("wr_rd_accept_spacing", line_t'(last_acc - a1), line_t'(LAT + 2));
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
